// File: rtl/beep_decoder.sv
// beep_decoder: recognises the buzzer alarm waveform on the active-low beep line.
// A tone FSM qualifies fall-to-fall spacing against the tone period. A group FSM
// counts tone bursts and flags a group once the line has been silent long enough.
module beep_decoder #(
    parameter int TONE_BIT  = 13,
    parameter int BURST_BIT = 23,
    parameter int TOL       = 1,
    parameter int BURSTS    = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_beep,
    input  logic       i_clr,
    output logic       o_tone,
    output logic [3:0] o_burst_cnt,
    output logic       o_alarm_pulse,
    output logic       o_alarm,
    output logic [7:0] o_alarm_cnt
);

    localparam int NT   = 1 << TONE_BIT;
    localparam int NB   = 1 << BURST_BIT;
    localparam int EG_W = TONE_BIT + 3;
    localparam int SC_W = BURST_BIT + 3;

    localparam logic [EG_W-1:0] TO     = EG_W'(4 * NT);
    localparam logic [EG_W-1:0] WIN_LO = EG_W'(2 * NT - TOL);
    localparam logic [EG_W-1:0] WIN_HI = EG_W'(2 * NT + TOL);
    localparam logic [SC_W-1:0] GG     = SC_W'(4 * NB);

    typedef enum logic [1:0] {T_IDLE, T_ARM, T_TONE} tstate_t;
    typedef enum logic [1:0] {G_IDLE, G_BURST, G_GAP} gstate_t;

    logic            r_beep_s;
    logic            r_beep_d;
    logic [EG_W-1:0] r_eg;
    tstate_t         r_tstate;
    tstate_t         w_tnext;
    logic            r_tone;
    logic            r_tone_d;
    logic            w_tone_nxt;
    logic [SC_W-1:0] r_sc;
    gstate_t         r_gstate;
    gstate_t         w_gnext;
    logic [3:0]      r_burst_cnt;
    logic [3:0]      w_bc_nxt;
    logic            w_fire;
    logic            r_pulse;
    logic            r_alarm;
    logic [7:0]      r_alarm_cnt;

    logic w_fall;
    logic w_hit;
    logic w_trise;
    logic w_tfall;

    assign w_fall  = r_beep_d & ~r_beep_s;
    // eg still holds the spacing since the previous fall on the cycle the fall is seen
    assign w_hit   = w_fall && (r_eg >= WIN_LO) && (r_eg <= WIN_HI);
    assign w_trise = r_tone & ~r_tone_d;
    assign w_tfall = ~r_tone & r_tone_d;

    // Two-stage input register; only these flops look at the raw beep line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beep_s <= 1'b1;
            r_beep_d <= 1'b1;
        end else begin
            r_beep_s <= i_beep;
            r_beep_d <= r_beep_s;
        end
    end

    // Fall-to-fall gap counter, saturating at the tone timeout
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_eg <= '0;
        else if (w_fall)
            r_eg <= '0;
        else if (r_eg != TO)
            r_eg <= r_eg + EG_W'(1);
    end

    // Tone FSM state register, tone output registered alongside it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tstate <= T_IDLE;
            r_tone   <= 1'b0;
            r_tone_d <= 1'b0;
        end else begin
            r_tstate <= w_tnext;
            r_tone   <= w_tone_nxt;
            r_tone_d <= r_tone;
        end
    end

    // Tone FSM next state: a fall inside the window keeps or gains tone, any other fall re-arms
    always_comb begin
        w_tnext = r_tstate;
        case (r_tstate)
            T_IDLE: if (w_fall) w_tnext = T_ARM;
            T_ARM, T_TONE: begin
                if (w_hit)
                    w_tnext = T_TONE;
                else if (w_fall)
                    w_tnext = T_ARM;
                else if (r_eg == TO)
                    w_tnext = T_IDLE;
            end
            default: w_tnext = T_IDLE;
        endcase
    end

    // Tone FSM output decode
    always_comb begin
        w_tone_nxt = (w_tnext == T_TONE);
    end

    // Silence counter follows the tone register, so sc = cycles that tone has read 0
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_sc <= '0;
        else if (w_tone_nxt)
            r_sc <= '0;
        else if (r_sc != GG)
            r_sc <= r_sc + SC_W'(1);
    end

    // Group FSM state register plus counters and alarm flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gstate    <= G_IDLE;
            r_burst_cnt <= '0;
            r_pulse     <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_gstate    <= w_gnext;
            r_burst_cnt <= w_bc_nxt;
            r_pulse     <= w_fire;
            if (w_fire)
                r_alarm_cnt <= r_alarm_cnt + 8'd1;
            // a completed group outranks a simultaneous clear
            if (r_pulse)
                r_alarm <= 1'b1;
            else if (i_clr)
                r_alarm <= 1'b0;
        end
    end

    // Group FSM next state
    always_comb begin
        w_gnext = r_gstate;
        case (r_gstate)
            G_IDLE:  if (w_trise) w_gnext = G_BURST;
            G_BURST: if (w_tfall) w_gnext = G_GAP;
            G_GAP: begin
                if (w_trise && (r_sc < GG))
                    w_gnext = G_BURST;
                else if (r_sc == GG)
                    w_gnext = G_IDLE;
            end
            default: w_gnext = G_IDLE;
        endcase
    end

    // Group FSM outputs: burst count update and the group-complete strobe
    always_comb begin
        w_bc_nxt = r_burst_cnt;
        w_fire   = 1'b0;
        case (r_gstate)
            G_IDLE: if (w_trise) w_bc_nxt = 4'd1;
            G_GAP: begin
                if (w_trise && (r_sc < GG)) begin
                    if (r_burst_cnt != 4'd15)
                        w_bc_nxt = r_burst_cnt + 4'd1;
                end else if (r_sc == GG) begin
                    w_bc_nxt = 4'd0;
                    w_fire   = (r_burst_cnt == 4'(BURSTS));
                end
            end
            default: ;
        endcase
    end

    assign o_tone        = r_tone;
    assign o_burst_cnt   = r_burst_cnt;
    assign o_alarm_pulse = r_pulse;
    assign o_alarm       = r_alarm;
    assign o_alarm_cnt   = r_alarm_cnt;

endmodule

// File: tb/tb_beep_decoder.sv
// Bench for beep_decoder: directed waveforms, alarm pulses checked by a scoreboard monitor.
module tb_beep_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       beep;
    logic       clr;
    logic       tone;
    logic [3:0] bc;
    logic       pulse;
    logic       alarm;
    logic [7:0] acnt;

    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rise  = 0;
    int   max_bc  = 0;
    logic tone_prev = 1'b0;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;
    exp_t sb_q[$];

    beep_decoder #(.TONE_BIT(2), .BURST_BIT(6), .TOL(1), .BURSTS(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_beep(beep), .i_clr(clr),
        .o_tone(tone), .o_burst_cnt(bc), .o_alarm_pulse(pulse),
        .o_alarm(alarm), .o_alarm_cnt(acnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every alarm pulse must match the next expected entry
    always @(negedge clk) begin
        exp_t e;
        if (pulse === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: pulse at cycle %0d, none expected", cyc);
            end else begin
                e = sb_q.pop_front();
                n_tests += 2;
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse_cycle: got %0d expected %0d", cyc, e.cyc);
                end
                if (int'(acnt) != e.cnt) begin
                    n_fail++;
                    $display("FAIL pulse_alarm_cnt: got %0d expected %0d", acnt, e.cnt);
                end
            end
        end
        if (tone === 1'b1 && tone_prev === 1'b0) n_rise++;
        tone_prev = tone;
        if (!$isunknown(bc) && int'(bc) > max_bc) max_bc = int'(bc);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic cl, input logic r);
        beep = b;
        clr  = cl;
        rst  = r;
        @(posedge clk);
        #1;
    endtask

    // Reference alarm generator: beep = !(c[2] & c[6] & !c[10])
    function automatic logic gen(input int c);
        logic [10:0] v;
        v = c[10:0];
        return !(v[2] & v[6] & !v[10]);
    endfunction

    // Compact valid group: 8 tone bursts made of a fall pair 8 apart, each burst
    // ended by a fall 2 cycles later, then silence. Last tone drop at edge 81,
    // silence counter full at edge 336, pulse visible after edge 337.
    task automatic short_group(input int cnt);
        int   base;
        logic b;
        base = cyc;
        sb_q.push_back('{base + 338, cnt});
        for (int s = 0; s < 340; s++) begin
            b = 1'b1;
            if (s <= 80 && ((s % 10) == 0 || (s % 10) == 8)) b = 1'b0;
            step(b, 1'b0, 1'b0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tone"}, int'(tone), 0);
        chk({tag, "_burst_cnt"}, int'(bc), 0);
        chk({tag, "_pulse"}, int'(pulse), 0);
        chk({tag, "_alarm"}, int'(alarm), 0);
        chk({tag, "_alarm_cnt"}, int'(acnt), 0);
    endtask

    initial begin
        int base;
        rst  = 1'b1;
        beep = 1'b1;
        clr  = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk_all_zero("reset");

        // Full generator group: last fall c=1020, tone drops after edge 1038,
        // pulse 256 cycles later after edge 1294
        n_rise = 0;
        max_bc = 0;
        base = cyc;
        sb_q.push_back('{base + 1295, 1});
        for (int c = 0; c < 1400; c++) step(gen(c), 1'b0, 1'b0);
        chk("full_tone_rises", n_rise, 8);
        chk("full_max_burst_cnt", max_bc, 8);
        chk("full_alarm", int'(alarm), 1);
        chk("full_alarm_cnt", int'(acnt), 1);
        chk("full_pending", sb_q.size(), 0);

        // Plain clear
        step(1'b1, 1'b1, 1'b0);
        chk("clr_alarm", int'(alarm), 0);
        chk("clr_alarm_cnt", int'(acnt), 1);

        // Generator gated off after 7 bursts: group silently dropped
        max_bc = 0;
        for (int c = 0; c < 1300; c++) step((c >= 896) ? 1'b1 : gen(c), 1'b0, 1'b0);
        chk("short7_max_burst_cnt", max_bc, 7);
        chk("short7_burst_cnt", int'(bc), 0);
        chk("short7_alarm", int'(alarm), 0);
        chk("short7_alarm_cnt", int'(acnt), 1);

        // Off-frequency square wave (period 12), then stuck low, then stuck high
        step(1'b1, 1'b0, 1'b1);
        n_rise = 0;
        max_bc = 0;
        for (int k = 0; k < 500; k++) step(((k / 6) % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        chk("sq12_tone_rises", n_rise, 0);
        chk("sq12_burst_cnt", max_bc, 0);
        chk("sq12_alarm_cnt", int'(acnt), 0);
        for (int k = 0; k < 300; k++) step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 1'b0);
        chk("stuck_tone_rises", n_rise, 0);
        chk("stuck_alarm", int'(alarm), 0);

        // Reset after the 4th burst; remaining 4 bursts are a short group
        for (int c = 0; c < 560; c++) step(gen(c), 1'b0, 1'b0);
        chk("pre_rst_burst_cnt", int'(bc), 4);
        step(gen(560), 1'b0, 1'b1);
        chk_all_zero("mid_rst");
        max_bc = 0;
        for (int c = 561; c < 1400; c++) step(gen(c), 1'b0, 1'b0);
        chk("post_rst_max_burst_cnt", max_bc, 4);
        chk("post_rst_burst_cnt", int'(bc), 0);
        chk("post_rst_alarm_cnt", int'(acnt), 0);

        // Next full group, with clr coincident with the pulse and then one cycle later
        base = cyc;
        sb_q.push_back('{base + 1295, 1});
        for (int c = 0; c < 1400; c++) begin
            step(gen(c), (c == 1295 || c == 1296), 1'b0);
            if (c == 1295) chk("clr_with_pulse_alarm", int'(alarm), 1);
            if (c == 1296) begin
                chk("clr_after_pulse_alarm", int'(alarm), 0);
                chk("clr_after_pulse_alarm_cnt", int'(acnt), 1);
            end
        end

        // 255 more groups: the 256th pulse since reset wraps alarm_cnt to 0
        for (int g = 0; g < 255; g++) short_group((g + 2) % 256);
        chk("wrap_alarm_cnt", int'(acnt), 0);
        chk("wrap_pending", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
